// File: rtl/axi4_lite_regs.sv
// rtl/axi4_lite_regs.sv - AXI4-Lite slave register file with per-register access pulses
module axi4_lite_regs #(
    parameter int             AW      = 32,
    parameter int             DW      = 32,
    parameter int             SW      = DW / 8,
    parameter int             RN      = 16,
    parameter logic [RN-1:0]  WR_MASK = {RN{1'b1}}
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [AW-1:0]     AWADDR,
    input  logic [2:0]        AWPROT,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DW-1:0]     WDATA,
    input  logic [SW-1:0]     WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [AW-1:0]     ARADDR,
    input  logic [2:0]        ARPROT,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [DW-1:0]     RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [RN*DW-1:0]  reg_o,
    input  logic [RN*DW-1:0]  reg_i,
    output logic [RN-1:0]     wr_pulse,
    output logic [RN-1:0]     rd_pulse
);

    localparam int LSB = $clog2(SW);
    localparam int IW  = AW - LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic              aw_held;
    logic [IW-1:0]     aw_idx;
    logic              w_held;
    logic [DW-1:0]     w_data;
    logic [SW-1:0]     w_strb;
    logic [DW-1:0]     regs [RN];

    logic              commit;
    logic              wr_ok;
    logic              ar_hs;
    logic [IW-1:0]     ar_idx;
    logic              rd_ok;
    logic [DW-1:0]     rd_data;

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{AWPROT, ARPROT, AWADDR[LSB-1:0], ARADDR[LSB-1:0]};

    assign AWREADY = !aw_held;
    assign WREADY  = !w_held;
    assign ARREADY = !RVALID || RREADY;
    assign commit  = aw_held && w_held && (!BVALID || BREADY);
    assign ar_hs   = ARVALID && ARREADY;
    assign ar_idx  = ARADDR[AW-1:LSB];

    always_comb begin
        wr_ok = 1'b0;
        for (int n = 0; n < RN; n++) begin
            if (aw_idx == IW'(n)) wr_ok = WR_MASK[n];
        end
    end

    // Read-only registers return the live fabric input captured at the handshake.
    always_comb begin
        rd_ok   = 1'b0;
        rd_data = '0;
        for (int n = 0; n < RN; n++) begin
            if (ar_idx == IW'(n)) begin
                rd_ok   = 1'b1;
                rd_data = WR_MASK[n] ? regs[n] : reg_i[n*DW +: DW];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held  <= 1'b0;
            aw_idx   <= '0;
            w_held   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            BVALID   <= 1'b0;
            BRESP    <= RESP_OKAY;
            RVALID   <= 1'b0;
            RRESP    <= RESP_OKAY;
            RDATA    <= '0;
            wr_pulse <= '0;
            rd_pulse <= '0;
            for (int n = 0; n < RN; n++) regs[n] <= '0;
        end else begin
            wr_pulse <= '0;
            rd_pulse <= '0;

            if (AWVALID && AWREADY) begin
                aw_held <= 1'b1;
                aw_idx  <= AWADDR[AW-1:LSB];
            end
            if (WVALID && WREADY) begin
                w_held <= 1'b1;
                w_data <= WDATA;
                w_strb <= WSTRB;
            end

            // A commit may overwrite a response being accepted this same cycle.
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                BVALID  <= 1'b1;
                BRESP   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                for (int n = 0; n < RN; n++) begin
                    if (WR_MASK[n] && aw_idx == IW'(n)) begin
                        wr_pulse[n] <= 1'b1;
                        for (int b = 0; b < SW; b++) begin
                            if (w_strb[b]) regs[n][b*8 +: 8] <= w_data[b*8 +: 8];
                        end
                    end
                end
            end else if (BREADY) begin
                BVALID <= 1'b0;
            end

            if (ar_hs) begin
                RVALID <= 1'b1;
                RDATA  <= rd_data;
                RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                for (int n = 0; n < RN; n++) begin
                    if (ar_idx == IW'(n)) rd_pulse[n] <= 1'b1;
                end
            end else if (RREADY) begin
                RVALID <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < RN; g++) begin : g_reg_o
        assign reg_o[g*DW +: DW] = regs[g];
    end

endmodule
